// File: rtl/sign_unit_scheduler_pkg.sv
// Shared types and constants for the sign unit scheduler.
// Holds the FSM encoding, operand widths and the round-robin pointer helper.
package sign_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int QUOT_W      = 36;
    localparam int ASP_W       = 72;
    localparam int SU_LATENCY  = 10;
    localparam int DEF_TIMEOUT = 16;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/sign_unit_scheduler_if.sv
// Request/response bus between the requesters and the sign unit scheduler.
// Operand and tag buses are packed per requester, index i at slice i.
interface sign_unit_scheduler_if
    import sign_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int TAGW = 8
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*QUOT_W-1:0] req_quotient;
    logic [NREQ*ASP_W-1:0]  req_asp_msw;
    logic [NREQ*TAGW-1:0]   req_tag;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_ready;
    logic                   resp_sign;
    logic [TAGW-1:0]        resp_tag;
    logic                   resp_err;

    modport master (
        output req_valid, req_quotient, req_asp_msw, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_sign, resp_tag, resp_err
    );

    modport slave (
        input  req_valid, req_quotient, req_asp_msw, req_tag, resp_ready,
        output req_ready, resp_valid, resp_sign, resp_tag, resp_err
    );
endinterface

// File: rtl/sign_unit_scheduler_rr_arbiter.sv
// Combinational round-robin grant: first valid request at or after ptr, wrapping.
// The pointer is owned and advanced by the scheduler.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_req
);
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any_req && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_req    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sign_unit_scheduler.sv
// Shares one sign unit among NREQ requesters: round-robin grant, unit restart
// via su_rst, done wait with watchdog, and a one-hot response to the winner.
//
// state    | meaning
// ST_IDLE  | unit parked in reset, granting the next valid requester
// ST_START | operands latched, unit held in reset one more cycle
// ST_WAIT  | unit running, watchdog counting towards TIMEOUT
// ST_RESP  | result presented to the granted requester until resp_ready
module sign_unit_scheduler
    import sign_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TAGW    = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    sign_unit_scheduler_if.slave bus,
    output logic              su_rst,
    output logic [QUOT_W-1:0] su_quotient,
    output logic [ASP_W-1:0]  su_asp_msw,
    input  logic              su_sign,
    input  logic              su_done,
    output logic              busy,
    output logic              err_sticky
);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     cur;
    logic [IW-1:0]     g_idx;
    logic [NREQ-1:0]   grant;
    logic              any_req;
    logic [WDW-1:0]    watchdog;
    logic [QUOT_W-1:0] sel_quot;
    logic [ASP_W-1:0]  sel_asp;
    logic [TAGW-1:0]   sel_tag;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (g_idx),
        .any_req   (any_req)
    );

    assign bus.req_ready = (state == ST_IDLE) ? grant : '0;

    always_comb begin
        sel_quot = '0;
        sel_asp  = '0;
        sel_tag  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (g_idx == IW'(k)) begin
                sel_quot = bus.req_quotient[k*QUOT_W +: QUOT_W];
                sel_asp  = bus.req_asp_msw[k*ASP_W +: ASP_W];
                sel_tag  = bus.req_tag[k*TAGW +: TAGW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            cur            <= '0;
            watchdog       <= '0;
            bus.resp_valid <= '0;
            bus.resp_sign  <= 1'b0;
            bus.resp_tag   <= '0;
            bus.resp_err   <= 1'b0;
            su_rst         <= 1'b1;
            su_quotient    <= '0;
            su_asp_msw     <= '0;
            busy           <= 1'b0;
            err_sticky     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        su_quotient  <= sel_quot;
                        su_asp_msw   <= sel_asp;
                        bus.resp_tag <= sel_tag;
                        cur          <= g_idx;
                        ptr          <= IW'(rr_next(int'(g_idx), NREQ));
                        busy         <= 1'b1;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    watchdog <= '0;
                    su_rst   <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (su_done) begin
                        bus.resp_sign  <= su_sign;
                        bus.resp_err   <= 1'b0;
                        bus.resp_valid <= NREQ'(1) << cur;
                        state          <= ST_RESP;
                    end else if (watchdog == WDW'(TIMEOUT - 1)) begin
                        // Hung unit: answer anyway so the requester is not stalled.
                        bus.resp_sign  <= 1'b0;
                        bus.resp_err   <= 1'b1;
                        err_sticky     <= 1'b1;
                        bus.resp_valid <= NREQ'(1) << cur;
                        state          <= ST_RESP;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready[cur]) begin
                        bus.resp_valid <= '0;
                        su_rst         <= 1'b1;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sign_unit_scheduler.sv
// Directed bench for sign_unit_scheduler with a behavioural sign unit stub
// that raises done SU_LATENCY cycles after su_rst falls (or never, when hung).
module tb_sign_unit_scheduler;
    import sign_sched_pkg::*;

    localparam int NREQ = 2;
    localparam int TAGW = 8;

    logic              clk;
    logic              rst;
    logic              su_rst;
    logic [QUOT_W-1:0] su_quotient;
    logic [ASP_W-1:0]  su_asp_msw;
    logic              su_sign;
    logic              su_done;
    logic              busy;
    logic              err_sticky;

    logic              stub_sign;
    logic              hang;
    logic [3:0]        su_cnt;

    int n_chk;
    int n_err;

    sign_unit_scheduler_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

    sign_unit_scheduler #(.NREQ(NREQ), .TAGW(TAGW), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .su_rst      (su_rst),
        .su_quotient (su_quotient),
        .su_asp_msw  (su_asp_msw),
        .su_sign     (su_sign),
        .su_done     (su_done),
        .busy        (busy),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (su_rst) su_cnt <= '0;
        else if (su_cnt < 4'(SU_LATENCY)) su_cnt <= su_cnt + 1'b1;
    end
    assign su_done = !su_rst && !hang && (su_cnt == 4'(SU_LATENCY));
    assign su_sign = su_done ? stub_sign : 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [35:0] q, input logic [71:0] a,
                         input logic [7:0] tag);
        bus.req_quotient[i*QUOT_W +: QUOT_W] = q;
        bus.req_asp_msw[i*ASP_W +: ASP_W]    = a;
        bus.req_tag[i*TAGW +: TAGW]          = tag;
        bus.req_valid[i]                     = 1'b1;
        #1;
        chk("req_ready", bus.req_ready, 2'(1) << i);
        step();
        bus.req_valid[i] = 1'b0;
        chk("start_su_rst", su_rst, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("su_quotient", su_quotient, q);
        chk("su_asp_msw", su_asp_msw, a);
    endtask

    // lat counts cycles since acceptance; issue() has already spent one.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (bus.resp_valid == '0 && lat < 60) begin
            step();
            lat++;
        end
        chk("resp_seen", bus.resp_valid != '0, 1'b1);
    endtask

    task automatic ack(input int i);
        bus.resp_ready[i] = 1'b1;
        step();
        bus.resp_ready[i] = 1'b0;
        chk("resp_drop", bus.resp_valid, 2'b00);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic run_txn(input int i, input logic [35:0] q, input logic [71:0] a,
                           input logic [7:0] tag, input logic ssign, input logic hang_in,
                           input logic exp_sign, input logic exp_err, input int exp_lat);
        int lat;
        stub_sign = ssign;
        hang      = hang_in;
        issue(i, q, a, tag);
        wait_resp(lat);
        chk("latency", lat, exp_lat);
        chk("resp_valid", bus.resp_valid, 2'(1) << i);
        chk("resp_sign", bus.resp_sign, exp_sign);
        chk("resp_tag", bus.resp_tag, tag);
        chk("resp_err", bus.resp_err, exp_err);
        ack(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int        lat;
        int        nresp;
        int        ngrant;
        logic [1:0] gseq [4];
        logic [1:0] rvld [4];
        logic [7:0] rtag [4];
        int        rcyc [4];
        logic      seen;

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        hang = 1'b0;
        stub_sign = 1'b0;
        bus.req_valid = '0;
        bus.req_quotient = '0;
        bus.req_asp_msw = '0;
        bus.req_tag = '0;
        bus.resp_ready = '0;
        repeat (3) step();

        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_resp_sign", bus.resp_sign, 1'b0);
        chk("rst_resp_tag", bus.resp_tag, 8'h00);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_su_rst", su_rst, 1'b1);
        chk("rst_su_quot", su_quotient, 36'd0);
        chk("rst_su_asp", su_asp_msw, 72'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_sticky", err_sticky, 1'b0);
        rst = 1'b0;
        step();

        // Single requests with the three reference operand sets.
        run_txn(0, 36'd0, {18'd200000, 54'd0}, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 13);
        run_txn(0, 36'd0, 72'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 13);
        run_txn(1, 36'd0, {18'd129075, 18'd202278, 36'd0}, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 13);

        // Both requesters continuously valid from ptr 0.
        do_reset();
        stub_sign = 1'b1;
        bus.req_quotient = {36'd222, 36'd111};
        bus.req_asp_msw = {72'd2, 72'd1};
        bus.req_tag = {8'h02, 8'h01};
        bus.resp_ready = 2'b11;
        bus.req_valid = 2'b11;
        nresp = 0;
        ngrant = 0;
        for (int c = 0; c < 100 && nresp < 4; c++) begin
            #1;
            if (bus.req_ready != '0 && ngrant < 4) begin
                gseq[ngrant] = bus.req_ready;
                ngrant++;
            end
            if (bus.resp_valid != '0) begin
                rvld[nresp] = bus.resp_valid;
                rtag[nresp] = bus.resp_tag;
                rcyc[nresp] = c;
                nresp++;
            end
            step();
        end
        bus.req_valid = 2'b00;
        chk("rr_resp_count", nresp, 4);
        chk("rr_first_cycle", rcyc[0], 13);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", gseq[k], (k % 2) ? 2'b10 : 2'b01);
            chk("rr_resp_valid", rvld[k], (k % 2) ? 2'b10 : 2'b01);
            chk("rr_tag", rtag[k], (k % 2) ? 8'h02 : 8'h01);
            if (k > 0) chk("rr_period", rcyc[k] - rcyc[k-1], 14);
        end
        for (int c = 0; c < 40 && busy; c++) step();
        chk("rr_drain", busy, 1'b0);
        bus.resp_ready = 2'b00;
        step();

        // Backpressure on requester 1 while requester 0 waits.
        stub_sign = 1'b1;
        issue(1, 36'd7, 72'd9, 8'h33);
        wait_resp(lat);
        chk("bp_latency", lat, 13);
        bus.req_quotient[35:0] = 36'd5;
        bus.req_tag[7:0] = 8'h44;
        bus.req_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.resp_ready[0] = (c >= 10);
            #1;
            chk("bp_valid", bus.resp_valid, 2'b10);
            chk("bp_sign", bus.resp_sign, 1'b1);
            chk("bp_tag", bus.resp_tag, 8'h33);
            chk("bp_no_grant", bus.req_ready, 2'b00);
            step();
        end
        bus.resp_ready = 2'b10;
        step();
        bus.resp_ready = 2'b00;
        chk("bp_drop", bus.resp_valid, 2'b00);
        #1;
        chk("bp_next_grant", bus.req_ready, 2'b01);
        step();
        bus.req_valid[0] = 1'b0;
        wait_resp(lat);
        chk("bp_next_latency", lat, 13);
        chk("bp_next_tag", bus.resp_tag, 8'h44);
        chk("bp_next_valid", bus.resp_valid, 2'b01);
        ack(0);

        // Hung unit, then a healthy one: err_sticky must survive.
        run_txn(0, 36'd1, 72'd1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 18);
        chk("to_sticky", err_sticky, 1'b1);
        run_txn(1, 36'd2, 72'd2, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 13);
        chk("to_sticky_kept", err_sticky, 1'b1);

        // Reset in the middle of WAIT.
        stub_sign = 1'b1;
        issue(0, 36'd3, 72'd3, 8'h99);
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_su_rst", su_rst, 1'b1);
        chk("mid_rst_valid", bus.resp_valid, 2'b00);
        chk("mid_rst_sticky", err_sticky, 1'b0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.resp_valid != '0) seen = 1'b1;
        end
        chk("mid_rst_no_resp", seen, 1'b0);
        run_txn(1, 36'd4, 72'd4, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 13);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sign_unit_scheduler.md
Name: sign_unit_scheduler

Overview:
- Shares one sign_calculation unit between NREQ requesters, e.g. parallel lift/scale cores that each need the rounding sign of a coefficient.
- Arbitrates round-robin and latches the winner's operands. Restarts the unit through its reset pin, waits for done, and returns the sign bit plus the caller's tag.
- Includes a watchdog so a hung unit cannot stall the requesters.

Parameters:
- NREQ, 2, number of requesters (2..8)
- TAGW, 8, width of the opaque request tag echoed in the response
- TIMEOUT, 16, max WAIT cycles before declaring an error (must be >= 12)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  one-hot accept strobe
- req_quotient  in  NREQ*36  requester i occupies bits [36i+35:36i]
- req_asp_msw  in  NREQ*72  requester i occupies bits [72i+71:72i]
- req_tag  in  NREQ*TAGW  tag per requester
- resp_valid  out  NREQ  one-hot response valid to the granted requester
- resp_ready  in  NREQ  per-requester response accept
- resp_sign  out  1  sign result (shared bus)
- resp_tag  out  TAGW  echoed tag (shared bus)
- resp_err  out  1  response produced by timeout; resp_sign is 0
- su_rst  out  1  drives the sign unit's rst
- su_quotient  out  36  held operand to the sign unit
- su_asp_msw  out  72  held operand to the sign unit
- su_sign  in  1  sign unit result
- su_done  in  1  sign unit done
- busy  out  1  high in every state except IDLE
- err_sticky  out  1  set on any timeout; cleared only by rst

Behaviour:
- Reset is rst (synchronous, active-high) on clock clk; all state and registers are reset synchronously.
- Reset values: state IDLE, rr pointer 0, req_ready 0, resp_valid 0, resp_sign 0, resp_tag 0, resp_err 0, su_rst 1, su operands 0, busy 0, err_sticky 0, watchdog 0.
- su_rst = 1 in IDLE and START and 0 in WAIT and RESP. The unit is therefore parked in its state 0 whenever it is unused.
- States:
  - IDLE:
    - Grant g = first index with req_valid high, searching from pointer ptr and wrapping modulo NREQ.
    - If any request is valid: req_ready[g]=1 for this cycle only (combinational from req_valid).
    - Latch quotient, asp_msw and tag of g. Store g. Set ptr <= (g+1) mod NREQ. Go to START.
    - If no request is valid: stay in IDLE, req_ready=0.
  - START: one cycle with su_rst high; go to WAIT with watchdog <= 0.
  - WAIT:
    - If su_done: latch su_sign into resp_sign, resp_err <= 0, go to RESP.
    - Else if watchdog == TIMEOUT-1: resp_sign <= 0, resp_err <= 1, err_sticky <= 1, go to RESP.
    - Else: watchdog++.
  - RESP:
    - resp_valid[g]=1; resp_sign, resp_tag and resp_err are stable.
    - On resp_ready[g]: go to IDLE, with resp_valid dropping the next cycle.
    - resp_ready of other indices is ignored.
- Operands su_quotient and su_asp_msw stay constant from START until the next grant.
- Latency with a healthy unit: accept at cycle T, START at T+1, unit state0 at T+2, su_done at T+12, resp_valid at T+13. Back-to-back throughput is one result per 14 cycles when resp_ready is high.
- Requester contract: hold valid/operands until req_ready. Dropping valid in the same cycle that the grant is evaluated is legal; that requester is then simply not selected.
- Simultaneous requests: round-robin; a requester that was just served has lowest priority on the next grant.
- rst mid-operation: abandon the transaction, return to IDLE and drop resp_valid. No response is issued for the lost request.

Decomposition:
- Shared package sign_sched_pkg holds:
  - state encoding (IDLE, START, WAIT, RESP; 2 bits)
  - QUOT_W=36, ASP_W=72
  - SU_LATENCY=10
  - default TIMEOUT
- One sub-module, rr_arbiter: inputs NREQ request vector and pointer; outputs one-hot grant, grant index and any_req. It is purely combinational and its pointer update lives in the scheduler.

Test Plan:
1. Single request: requester 0, quotient=0, asp_msw[71:54]=200000, all other bits 0, tag=0x5A → resp_valid[0] at T+13 with sign=1, tag=0x5A, err=0.
2. Same request with asp_msw=0 → sign=0. Then quotient=0, asp_msw[71:54]=129075, asp_msw[53:36]=202278 → sign=0 (equal to q/2, no borrow).
3. Both requesters valid continuously with ptr=0 → grants alternate 0,1,0,1. Each response carries the matching tag (0x01/0x02), and one response is issued every 14 cycles.
4. Backpressure: resp_ready[1] held low 20 cycles → resp_valid[1], resp_sign and resp_tag stay constant. No new req_ready is issued until the handshake completes.
5. Timeout: bench forces su_done=0 with TIMEOUT=16 → resp_valid at T+18 with resp_err=1, sign=0, err_sticky=1. err_sticky persists across the next good transaction.
6. Reset at T+6 mid-WAIT → state IDLE, su_rst=1, resp_valid=0 the next cycle. A fresh request afterwards completes normally.
